// File: rtl/inv_keyexpansion_if.sv
// Port bundle for the AES-128 inverse key schedule: control inputs, round-key stream and status.
// Handshake: a round key transfers on a rising edge where keyValid && ready; while keyValid is high
// and ready is low, roundKey, round and keyValid hold stable.
interface inv_keyexpansion_if;
    logic         start;
    logic         reuse;
    logic [127:0] key;
    logic         ready;
    logic [127:0] roundKey;
    logic         keyValid;
    logic [3:0]   round;
    logic         busy;
    logic         done;
    logic [1:0]   dbg_state;

    modport master (
        output start, reuse, key, ready,
        input  roundKey, keyValid, round, busy, done, dbg_state
    );

    modport slave (
        input  start, reuse, key, ready,
        output roundKey, keyValid, round, busy, done, dbg_state
    );
endinterface

// File: rtl/inv_keyexpansion.sv
// AES-128 decryption round-key generator: expands forward to round 10, then walks back to round 0,
// one key per handshake. The round-10 key is cached so a repeat schedule can skip the expansion.
module inv_keyexpansion (
    input  logic              clk,
    input  logic              reset,
    inv_keyexpansion_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXPAND = 2'd1,
        EMIT   = 2'd2
    } state_t;

    state_t       state_q, state_d;
    logic [127:0] key_q, key_d;
    logic [127:0] cache_q, cache_d;
    logic         cache_valid_q, cache_valid_d;
    logic [7:0]   rcon_q, rcon_d;
    logic [3:0]   step_q, step_d;
    logic [3:0]   round_q, round_d;
    logic         done_q, done_d;

    logic [31:0] w0, w1, w2, w3;
    logic [31:0] fwd_sub, inv_sub;
    logic [31:0] fw0, fw1, fw2, fw3;
    logic [31:0] iw0, iw1, iw2, iw3;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return b[7] ? ({b[6:0], 1'b0} ^ 8'h1b) : {b[6:0], 1'b0};
    endfunction

    function automatic logic [7:0] inv_xtime(input logic [7:0] b);
        logic [8:0] t;
        t = {1'b0, b} ^ 9'h11b;
        return b[0] ? t[8:1] : {1'b0, b[7:1]};
    endfunction

    assign w0 = key_q[127:96];
    assign w1 = key_q[95:64];
    assign w2 = key_q[63:32];
    assign w3 = key_q[31:0];

    subword u_fwd_sub (
        .word_i ({w3[23:0], w3[31:24]}),
        .word_o (fwd_sub)
    );

    assign fw0 = w0 ^ fwd_sub ^ {rcon_q, 24'h0};
    assign fw1 = w1 ^ fw0;
    assign fw2 = w2 ^ fw1;
    assign fw3 = w3 ^ fw2;

    // The inverse step recovers the previous w3 first, since the S-box input of w0 depends on it.
    assign iw3 = w3 ^ w2;
    assign iw2 = w2 ^ w1;
    assign iw1 = w1 ^ w0;

    subword u_inv_sub (
        .word_i ({iw3[23:0], iw3[31:24]}),
        .word_o (inv_sub)
    );

    assign iw0 = w0 ^ inv_sub ^ {rcon_q, 24'h0};

    always_comb begin
        state_d       = state_q;
        key_d         = key_q;
        cache_d       = cache_q;
        cache_valid_d = cache_valid_q;
        rcon_d        = rcon_q;
        step_d        = step_q;
        round_d       = round_q;
        done_d        = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (bus.reuse && cache_valid_q) begin
                        key_d   = cache_q;
                        rcon_d  = 8'h36;
                        round_d = 4'd10;
                        state_d = EMIT;
                    end else begin
                        key_d   = bus.key;
                        rcon_d  = 8'h01;
                        step_d  = 4'd0;
                        state_d = EXPAND;
                    end
                end
            end
            EXPAND: begin
                key_d  = {fw0, fw1, fw2, fw3};
                step_d = step_q + 4'd1;
                if (step_q == 4'd9) begin
                    // rcon stays at 0x36: it is exactly the constant the first inverse step needs.
                    cache_d       = {fw0, fw1, fw2, fw3};
                    cache_valid_d = 1'b1;
                    round_d       = 4'd10;
                    state_d       = EMIT;
                end else begin
                    rcon_d = xtime(rcon_q);
                end
            end
            EMIT: begin
                if (bus.ready) begin
                    if (round_q != 4'd0) begin
                        key_d   = {iw0, iw1, iw2, iw3};
                        round_d = round_q - 4'd1;
                        rcon_d  = inv_xtime(rcon_q);
                    end else begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            key_q         <= '0;
            cache_q       <= '0;
            cache_valid_q <= 1'b0;
            rcon_q        <= 8'h01;
            step_q        <= 4'd0;
            round_q       <= 4'd0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            key_q         <= key_d;
            cache_q       <= cache_d;
            cache_valid_q <= cache_valid_d;
            rcon_q        <= rcon_d;
            step_q        <= step_d;
            round_q       <= round_d;
            done_q        <= done_d;
        end
    end

    assign bus.roundKey  = key_q;
    assign bus.keyValid  = (state_q == EMIT);
    assign bus.round     = round_q;
    assign bus.busy      = (state_q != IDLE);
    assign bus.done      = done_q;
    assign bus.dbg_state = state_q;
endmodule

// Four parallel AES S-box lookups on a 32-bit word.
module subword (
    input  logic [31:0] word_i,
    output logic [31:0] word_o
);
    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    assign word_o = {SBOX[word_i[31:24]], SBOX[word_i[23:16]], SBOX[word_i[15:8]], SBOX[word_i[7:0]]};
endmodule

// File: tb/tb_inv_keyexpansion.sv
// Bench for inv_keyexpansion: forward-expansion reference model feeds an expected queue of
// {round, key} that is drained as the DUT hands keys over.
module tb_inv_keyexpansion;
    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    inv_keyexpansion_if bus ();

    inv_keyexpansion dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;

    int           checks   = 0;
    int           failures = 0;
    logic [131:0] exp_q[$];
    logic [7:0]   sbox_m [256];
    logic [127:0] model_rk [11];
    logic [127:0] obs_rk [11];
    logic [127:0] mid_key;
    int           cnt;

    task automatic check(input string tag, input logic [132:0] obs, input logic [132:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa, bb;
        p = 8'h00; aa = a; bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = aa[7] ? ({aa[6:0], 1'b0} ^ 8'h1b) : {aa[6:0], 1'b0};
            bb = {1'b0, bb[7:1]};
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl1(input logic [7:0] b);
        return {b[6:0], b[7]};
    endfunction

    // S-box derived from GF(2^8) inversion and the affine map, independent of any lookup table.
    task automatic build_sbox();
        logic [7:0] inv, r1, r2, r3, r4;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256 && x != 0; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            r1 = rotl1(inv); r2 = rotl1(r1); r3 = rotl1(r2); r4 = rotl1(r3);
            sbox_m[x] = inv ^ r1 ^ r2 ^ r3 ^ r4 ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] sub_m(input logic [31:0] w);
        return {sbox_m[w[31:24]], sbox_m[w[23:16]], sbox_m[w[15:8]], sbox_m[w[7:0]]};
    endfunction

    task automatic expand_model(input logic [127:0] k);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t  = sub_m({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) model_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    // Drive one schedule and drain it; model_rk must already hold the expected keys.
    task automatic run_schedule(input string name, input logic [127:0] k, input logic rsel,
                                input int exp_lat, input bit rand_ready, input bit pulse_mid);
        int lat;
        int guard;
        bit fin;
        for (int r = 0; r < 11; r++) obs_rk[r] = 'x;
        exp_q.delete();
        for (int r = 10; r >= 0; r--) exp_q.push_back({4'(r), model_rk[r]});
        bus.start = 1'b1; bus.reuse = rsel; bus.key = k;
        lat = 0;
        do begin
            @(negedge clk);
            bus.start = 1'b0; bus.reuse = 1'b0;
            lat++;
            if (lat == 2 && exp_lat > 2) check({name, " busy_expand"}, {132'd0, bus.busy}, 133'd1);
            if (pulse_mid && lat == 4) begin
                bus.start = 1'b1; bus.key = ~k;
            end
        end while (!bus.keyValid && lat < 40);
        check({name, " latency"}, 133'(lat), 133'(exp_lat));

        guard = 0; fin = 1'b0;
        while (!fin && guard < 200) begin
            check({name, " key"}, {bus.keyValid, bus.round, bus.roundKey}, {1'b1, exp_q[0]});
            bus.ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (pulse_mid && guard == 2) begin
                bus.start = 1'b1; bus.key = ~k;
            end
            if (bus.ready) begin
                if (bus.round <= 4'd10) obs_rk[bus.round] = bus.roundKey;
                void'(exp_q.pop_front());
                fin = (exp_q.size() == 0);
            end
            @(negedge clk);
            bus.start = 1'b0; bus.ready = 1'b0;
            guard++;
        end
        check({name, " drained"}, {132'd0, fin}, 133'd1);
        check({name, " done_pulse"}, {130'd0, bus.done, bus.busy, bus.keyValid}, {130'd0, 3'b100});
        @(negedge clk);
        check({name, " done_low"}, {131'd0, bus.done, bus.busy}, 133'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        bus.start = 1'b0; bus.reuse = 1'b0; bus.key = '0; bus.ready = 1'b0;
        build_sbox();
        repeat (3) @(negedge clk);
        check("reset outputs", {bus.keyValid, bus.round, bus.roundKey}, 133'd0);
        check("reset status", {131'd0, bus.busy, bus.done}, 133'd0);
        reset = 1'b0;
        @(negedge clk);

        // Empty cache: reuse falls back to a full expansion.
        expand_model(FIPS_KEY);
        run_schedule("reuse_miss", FIPS_KEY, 1'b1, 11, 1'b0, 1'b0);
        check("reuse_miss r10", {5'd0, obs_rk[10]}, {5'd0, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6});

        run_schedule("fips", FIPS_KEY, 1'b0, 11, 1'b0, 1'b0);
        check("fips r10", {5'd0, obs_rk[10]}, {5'd0, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6});
        check("fips r9", {5'd0, obs_rk[9]}, {5'd0, 128'hac7766f319fadc2128d12941575c006e});
        check("fips r1", {5'd0, obs_rk[1]}, {5'd0, 128'ha0fafe1788542cb123a339392a6c7605});
        check("fips r0", {5'd0, obs_rk[0]}, {5'd0, FIPS_KEY});

        run_schedule("backpressure", FIPS_KEY, 1'b0, 11, 1'b1, 1'b0);

        run_schedule("reuse_hit", 128'h0, 1'b1, 1, 1'b0, 1'b0);
        check("reuse_hit r10", {5'd0, obs_rk[10]}, {5'd0, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6});

        mid_key = {$urandom(), $urandom(), $urandom(), $urandom()};
        expand_model(mid_key);
        run_schedule("mid_start", mid_key, 1'b0, 11, 1'b1, 1'b1);

        expand_model(128'h0);
        run_schedule("zero_key", 128'h0, 1'b0, 11, 1'b0, 1'b0);
        check("zero r10", {5'd0, obs_rk[10]}, {5'd0, 128'hb4ef5bcb3e92e21123e951cf6f8f188e});
        check("zero r1", {5'd0, obs_rk[1]}, {5'd0, 128'h62636363626363636263636362636363});

        // Reset in the middle of EMIT, then a reuse start must re-expand.
        bus.start = 1'b1; bus.reuse = 1'b0; bus.key = FIPS_KEY;
        @(negedge clk);
        bus.start = 1'b0;
        cnt = 0;
        while (!bus.keyValid && cnt < 40) begin @(negedge clk); cnt++; end
        bus.ready = 1'b1;
        cnt = 0;
        while (bus.round != 4'd5 && cnt < 20) begin @(negedge clk); cnt++; end
        check("rst_at5 round", {129'd0, bus.round}, 133'd5);
        reset = 1'b1; bus.ready = 1'b0;
        @(negedge clk);
        check("rst_at5 outputs", {bus.keyValid, bus.round, bus.roundKey}, 133'd0);
        check("rst_at5 status", {131'd0, bus.busy, bus.done}, 133'd0);
        reset = 1'b0;
        @(negedge clk);
        expand_model(FIPS_KEY);
        run_schedule("reuse_after_reset", FIPS_KEY, 1'b1, 11, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
